// File: rtl/write_enable_sequencer_if.sv
// Request/response bundle between the control unit (master) and the
// write-enable sequencer (slave). The issue_count signal exists only when
// WE_SEQ_STATS_EN is defined.
interface write_enable_sequencer_if #(
  parameter int NUM_REGS = 7,
  parameter int SEL_W    = 3
);
  logic                req_valid;
  logic [SEL_W-1:0]    req_sel;
  logic                req_ready;
  logic                flush;
  logic [NUM_REGS-1:0] we;
  logic                busy;
  logic                err;
`ifdef WE_SEQ_STATS_EN
  logic [15:0]         issue_count;

  modport master (
    output req_valid, req_sel, flush,
    input  req_ready, we, busy, err, issue_count
  );

  modport slave (
    input  req_valid, req_sel, flush,
    output req_ready, we, busy, err, issue_count
  );
`else
  modport master (
    output req_valid, req_sel, flush,
    input  req_ready, we, busy, err
  );

  modport slave (
    input  req_valid, req_sel, flush,
    output req_ready, we, busy, err
  );
`endif
endinterface

// File: rtl/write_enable_sequencer.sv
// Register write-enable sequencer. Select codes are decoded at the point of
// acceptance and the resulting masks are queued in a small FIFO; each mask is
// then driven on we for PULSE_CYCLES clocks, back-to-back when more are queued.
// Code NUM_REGS issues COMBO_MASK; codes above it are dropped and flagged on err.
// Optional feature: define WE_SEQ_STATS_EN to add the 16-bit issue_count output.
module write_enable_sequencer #(
  parameter int                  NUM_REGS     = 7,
  parameter int                  SEL_W        = 3,
  parameter logic [NUM_REGS-1:0] COMBO_MASK   = 7'b0010100,
  parameter int                  FIFO_DEPTH   = 4,
  parameter int                  PULSE_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  write_enable_sequencer_if.slave bus
);

  localparam int                 PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                 CNT_W     = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [SEL_W-1:0]   SEL_COMBO = SEL_W'(NUM_REGS);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [NUM_REGS-1:0] r_we;
  logic [NUM_REGS-1:0] w_we_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                r_err;
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;
  logic [NUM_REGS-1:0] r_mem [FIFO_DEPTH];

  logic [NUM_REGS-1:0] w_onehot;
  logic [NUM_REGS-1:0] w_dec_mask;
  logic                w_sel_valid;
  logic                w_full;
  logic                w_empty;
  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_err_next;
  logic [NUM_REGS-1:0] w_head;

  // One-hot decode of ordinary register codes
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_dec
      assign w_onehot[gi] = (bus.req_sel == SEL_W'(gi));
    end
  endgenerate

  assign w_sel_valid = (bus.req_sel <= SEL_COMBO);
  assign w_dec_mask  = (bus.req_sel == SEL_COMBO) ? COMBO_MASK : w_onehot;

  // The extra top pointer bit distinguishes full from empty when the indices match
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  // Ready depends only on the current occupancy, so a pop on the same edge
  // never lets a request slip into a full queue. Flush discards the offer.
  assign w_accept   = bus.req_valid & ~w_full & ~bus.flush;
  assign w_push     = w_accept & w_sel_valid;
  assign w_err_next = w_accept & ~w_sel_valid;

  assign bus.req_ready = ~w_full;
  assign bus.we        = r_we;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state == S_ACTIVE) | ~w_empty;

  // Queue storage: written only on push, never reset (entries are masked by pointers)
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_dec_mask;
    end
  end

  // Queue pointers and the one-cycle error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= w_err_next;
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  // Sequencer state, registered mask and hold counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_we    <= w_we_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic: load a new mask from the queue or hold / release the current one
  always_comb begin
    w_state_next = r_state;
    w_we_next    = r_we;
    w_cnt_next   = r_cnt;
    w_pop        = 1'b0;
    if (bus.flush) begin
      w_state_next = S_IDLE;
      w_we_next    = '0;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_we_next = '0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_we_next    = w_head;
            w_cnt_next   = CNT_LOAD;
            w_state_next = S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (r_cnt != '0) begin
            w_cnt_next = r_cnt - 1'b1;
          end else if (!w_empty) begin
            w_pop      = 1'b1;
            w_we_next  = w_head;
            w_cnt_next = CNT_LOAD;
          end else begin
            w_we_next    = '0;
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_we_next    = '0;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

`ifdef WE_SEQ_STATS_EN
  logic [15:0] r_issue_count;

  // Count every mask taken from the queue; wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_count <= '0;
    end else if (w_pop) begin
      r_issue_count <= r_issue_count + 16'd1;
    end
  end

  assign bus.issue_count = r_issue_count;
`endif

endmodule

// File: tb/tb_write_enable_sequencer.sv
// Testbench for write_enable_sequencer (NUM_REGS=6 so code 7 is invalid,
// PULSE_CYCLES=2). A queue-based reference model predicts the outputs after
// every clock edge; a separate monitor pops and compares on the falling edge.
// Define WE_SEQ_STATS_EN to also check issue_count.
module tb_write_enable_sequencer;
  localparam int              NR    = 6;
  localparam int              SW    = 3;
  localparam logic [NR-1:0]   COMBO = 6'b010100;
  localparam int              DEPTH = 4;
  localparam int              P     = 2;

  typedef struct packed {
    logic [NR-1:0] we;
    logic          busy;
    logic          ready;
    logic          err;
  } exp_t;

  logic clk;
  logic rst_n;

  write_enable_sequencer_if #(.NUM_REGS(NR), .SEL_W(SW)) bus ();

  write_enable_sequencer #(
    .NUM_REGS    (NR),
    .SEL_W       (SW),
    .COMBO_MASK  (COMBO),
    .FIFO_DEPTH  (DEPTH),
    .PULSE_CYCLES(P)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t          sb[$];
  logic [NR-1:0] m_q[$];
  logic [NR-1:0] m_act;
  int            m_left;
  int            m_issues;
  int            n_cmp;
  int            n_bad;

  function automatic void chk(input string name, input logic [NR-1:0] got, input logic [NR-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [NR-1:0] decode(input int sel, output bit ok);
    ok = 1'b1;
    if (sel < NR)  return NR'(1 << sel);
    if (sel == NR) return COMBO;
    ok = 1'b0;
    return '0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_act    = '0;
    m_left   = 0;
    m_issues = 0;
  endtask

  // Apply one cycle of stimulus and push the predicted post-edge outputs
  task automatic step(input bit v, input int sel, input bit fl);
    exp_t          e;
    bit            ok;
    bit            acc;
    logic [NR-1:0] mask;
    bus.req_valid = v;
    bus.req_sel   = SW'(sel);
    bus.flush     = fl;
    @(posedge clk);
    acc   = v && (m_q.size() < DEPTH) && !fl;
    mask  = decode(sel, ok);
    e.err = acc && !ok;
    if (fl) begin
      m_q.delete();
      m_act  = '0;
      m_left = 0;
    end else begin
      if (m_left > 1) begin
        m_left--;
      end else if (m_q.size() > 0) begin
        m_act  = m_q.pop_front();
        m_left = P;
        m_issues++;
      end else begin
        m_act  = '0;
        m_left = 0;
      end
      if (acc && ok) m_q.push_back(mask);
    end
    e.we    = m_act;
    e.busy  = (m_left > 0) || (m_q.size() > 0);
    e.ready = (m_q.size() < DEPTH);
    sb.push_back(e);
    $display("cyc v=%0d sel=%0d flush=%0d -> exp we=%b busy=%0d rdy=%0d err=%0d",
             v, sel, fl, e.we, e.busy, e.ready, e.err);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0);
  endtask

  // Monitor: compare the DUT against the oldest prediction on every falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("we",    bus.we,                e.we);
        chk("busy",  NR'(bus.busy),         NR'(e.busy));
        chk("ready", NR'(bus.req_ready),    NR'(e.ready));
        chk("err",   NR'(bus.err),          NR'(e.err));
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_reset();
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    bus.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    chk("rst_we",    bus.we,               NR'(0));
    chk("rst_busy",  NR'(bus.busy),        NR'(0));
    chk("rst_ready", NR'(bus.req_ready),   NR'(1));
    chk("rst_err",   NR'(bus.err),         NR'(0));
    idle(1);

    // Async reset in the middle of a sel=2 pulse
    step(1'b1, 2, 1'b0);
    step(1'b0, 0, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we", bus.we, NR'(0));
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    chk("post_rst_busy",  NR'(bus.busy),      NR'(0));
    chk("post_rst_ready", NR'(bus.req_ready), NR'(1));
    idle(1);

    // Single pulse, then combo followed back-to-back by code 0
    step(1'b1, 3, 1'b0);
    idle(4);
    step(1'b1, 6, 1'b0);
    step(1'b1, 0, 1'b0);
    idle(6);

    // Hold valid while active until the queue fills, then drain
    for (int i = 0; i < 8; i++) step(1'b1, i % 6, 1'b0);
    idle(12);

    // Invalid code
    step(1'b1, 7, 1'b0);
    idle(3);

    // Flush with entries queued and a request offered on the flush edge
    step(1'b1, 1, 1'b0);
    step(1'b1, 2, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 4, 1'b0);
    step(1'b1, 5, 1'b1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 9) < 6), int'($urandom_range(0, 7)), ($urandom_range(0, 29) == 0));
    end
    idle(20);

`ifdef WE_SEQ_STATS_EN
    chk("issue_count_lo", bus.issue_count[NR-1:0], NR'(m_issues));
    chk("issue_count_hi", bus.issue_count[15:NR], (16-NR)'(m_issues >> NR));
`endif

    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
